// File: rtl/multichannel_dds.sv
// multichannel_dds: time-multiplexed DDS, NUM_CHANNELS phase accumulators
// sharing one quarter-wave LUT and a 3-stage pipeline, with per-channel chirp.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                advance the channel scheduler by one channel
//   sync_clear            clear accumulators, scheduler and pipeline valids
//   cfg_wr/ch/addr/data   per-channel FCW(0) / PHASE_OFFSET(1) / SWEEP_STEP(2)
//   lut_wr_en/addr/data   quarter-wave magnitude table load
//   out_valid, out_ch     sample strobe and channel tag
//   sine_out, cosine_out  signed two's-complement samples
module multichannel_dds #(
    parameter int PHASE_WIDTH    = 24,
    parameter int OUTPUT_WIDTH   = 12,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int NUM_CHANNELS   = 4,
    parameter int CH_WIDTH       = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      sync_clear,
    input  logic                      cfg_wr,
    input  logic [CH_WIDTH-1:0]       cfg_ch,
    input  logic [1:0]                cfg_addr,
    input  logic [PHASE_WIDTH-1:0]    cfg_data,
    input  logic                      lut_wr_en,
    input  logic [LUT_ADDR_WIDTH-1:0] lut_wr_addr,
    input  logic [OUTPUT_WIDTH-2:0]   lut_wr_data,
    output logic                      out_valid,
    output logic [CH_WIDTH-1:0]       out_ch,
    output logic [OUTPUT_WIDTH-1:0]   sine_out,
    output logic [OUTPUT_WIDTH-1:0]   cosine_out
);
    localparam int PW  = PHASE_WIDTH;
    localparam int LAW = LUT_ADDR_WIDTH;
    localparam int OW  = OUTPUT_WIDTH;
    localparam int MW  = OUTPUT_WIDTH - 1;
    localparam logic [CH_WIDTH-1:0] CH_LAST = CH_WIDTH'(NUM_CHANNELS - 1);

    logic [PW-1:0] acc_q  [NUM_CHANNELS];
    logic [PW-1:0] acc_d  [NUM_CHANNELS];
    logic [PW-1:0] fcw_q  [NUM_CHANNELS];
    logic [PW-1:0] fcw_d  [NUM_CHANNELS];
    logic [PW-1:0] off_q  [NUM_CHANNELS];
    logic [PW-1:0] off_d  [NUM_CHANNELS];
    logic [PW-1:0] step_q [NUM_CHANNELS];
    logic [PW-1:0] step_d [NUM_CHANNELS];
    logic [CH_WIDTH-1:0] ch_cnt_q, ch_cnt_d;
    logic [MW-1:0] lut_q [2**LAW];

    logic go;
    logic cfg_ok;
    logic [31:0] cfg_ch_ext;

    // sync_clear wins over enable for the whole cycle
    assign go         = enable && !sync_clear;
    assign cfg_ch_ext = 32'(cfg_ch);
    assign cfg_ok     = cfg_wr && (cfg_ch_ext < 32'(NUM_CHANNELS))
                        && (cfg_addr != 2'd3);

    // Stage 0 phase from the pre-update accumulator of the scheduled channel
    logic [PW-1:0] phase_s0;
    always_comb begin
        phase_s0 = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (ch_cnt_q == CH_WIDTH'(c)) begin
                phase_s0 = acc_q[c] + off_q[c];
            end
        end
    end

    // A config write to FCW lands after the sweep update, so it overrides it
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            acc_d[c]  = acc_q[c];
            fcw_d[c]  = fcw_q[c];
            off_d[c]  = off_q[c];
            step_d[c] = step_q[c];
            if (sync_clear) begin
                acc_d[c] = '0;
            end else if (go && ch_cnt_q == CH_WIDTH'(c)) begin
                acc_d[c] = acc_q[c] + fcw_q[c];
                fcw_d[c] = fcw_q[c] + step_q[c];
            end
            if (cfg_ok && cfg_ch == CH_WIDTH'(c)) begin
                case (cfg_addr)
                    2'd0:    fcw_d[c]  = cfg_data;
                    2'd1:    off_d[c]  = cfg_data;
                    2'd2:    step_d[c] = cfg_data;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        ch_cnt_d = ch_cnt_q;
        if (sync_clear) begin
            ch_cnt_d = '0;
        end else if (enable) begin
            ch_cnt_d = (ch_cnt_q == CH_LAST) ? '0 : ch_cnt_q + CH_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt_q <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                acc_q[c]  <= '0;
                fcw_q[c]  <= '0;
                off_q[c]  <= '0;
                step_q[c] <= '0;
            end
        end else begin
            ch_cnt_q <= ch_cnt_d;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                acc_q[c]  <= acc_d[c];
                fcw_q[c]  <= fcw_d[c];
                off_q[c]  <= off_d[c];
                step_q[c] <= step_d[c];
            end
        end
    end

    // Quarter-wave fold: odd quadrants mirror the index, upper half negates.
    // Cosine is the sine one quadrant ahead.
    logic [1:0]     quad, quad_c;
    logic [LAW-1:0] idx;
    assign quad   = phase_s0[PW-1 -: 2];
    assign idx    = phase_s0[PW-3 -: LAW];
    assign quad_c = quad + 2'd1;

    logic                s1_valid_q, s1_sneg_q, s1_cneg_q;
    logic [CH_WIDTH-1:0] s1_ch_q;
    logic [LAW-1:0]      s1_sidx_q, s1_cidx_q;
    logic                s2_valid_q, s2_sneg_q, s2_cneg_q;
    logic [CH_WIDTH-1:0] s2_ch_q;
    logic [MW-1:0]       s2_smag_q, s2_cmag_q;
    logic                out_valid_q;
    logic [CH_WIDTH-1:0] out_ch_q;
    logic [OW-1:0]       sin_q, cos_q;
    logic [OW-1:0]       sin_d, cos_d;

    always_comb begin
        sin_d = {1'b0, s2_smag_q};
        cos_d = {1'b0, s2_cmag_q};
        if (s2_sneg_q) sin_d = -{1'b0, s2_smag_q};
        if (s2_cneg_q) cos_d = -{1'b0, s2_cmag_q};
    end

    // Table has no reset; read-before-write gives old data on a collision
    always_ff @(posedge clk) begin
        if (lut_wr_en) lut_q[lut_wr_addr] <= lut_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sneg_q   <= 1'b0;
            s1_cneg_q   <= 1'b0;
            s1_ch_q     <= '0;
            s1_sidx_q   <= '0;
            s1_cidx_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_sneg_q   <= 1'b0;
            s2_cneg_q   <= 1'b0;
            s2_ch_q     <= '0;
            s2_smag_q   <= '0;
            s2_cmag_q   <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            sin_q       <= '0;
            cos_q       <= '0;
        end else begin
            s1_valid_q  <= go;
            s2_valid_q  <= s1_valid_q && !sync_clear;
            out_valid_q <= s2_valid_q && !sync_clear;
            if (go) begin
                s1_ch_q   <= ch_cnt_q;
                s1_sidx_q <= quad[0] ? ~idx : idx;
                s1_cidx_q <= quad_c[0] ? ~idx : idx;
                s1_sneg_q <= quad[1];
                s1_cneg_q <= quad_c[1];
            end
            if (s1_valid_q) begin
                s2_ch_q   <= s1_ch_q;
                s2_smag_q <= lut_q[s1_sidx_q];
                s2_cmag_q <= lut_q[s1_cidx_q];
                s2_sneg_q <= s1_sneg_q;
                s2_cneg_q <= s1_cneg_q;
            end
            if (s2_valid_q && !sync_clear) begin
                out_ch_q <= s2_ch_q;
                sin_q    <= sin_d;
                cos_q    <= cos_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign sine_out   = sin_q;
    assign cosine_out = cos_q;

endmodule

// File: tb/tb_multichannel_dds.sv
// tb_multichannel_dds: directed bench for multichannel_dds with the
// table lut[i] = 8*i and CH_WIDTH=3 so out-of-range channels can be driven.
module tb_multichannel_dds;
    localparam int PW  = 24;
    localparam int OW  = 12;
    localparam int LAW = 8;
    localparam int NCH = 4;
    localparam int CW  = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           enable = 1'b0;
    logic           sync_clear = 1'b0;
    logic           cfg_wr = 1'b0;
    logic [CW-1:0]  cfg_ch = '0;
    logic [1:0]     cfg_addr = '0;
    logic [PW-1:0]  cfg_data = '0;
    logic           lut_wr_en = 1'b0;
    logic [LAW-1:0] lut_wr_addr = '0;
    logic [OW-2:0]  lut_wr_data = '0;
    logic           out_valid;
    logic [CW-1:0]  out_ch;
    logic [OW-1:0]  sine_out;
    logic [OW-1:0]  cosine_out;

    int checks = 0;
    int fails  = 0;

    multichannel_dds #(
        .PHASE_WIDTH    (PW),
        .OUTPUT_WIDTH   (OW),
        .LUT_ADDR_WIDTH (LAW),
        .NUM_CHANNELS   (NCH),
        .CH_WIDTH       (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sync_clear  (sync_clear),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_addr (lut_wr_addr),
        .lut_wr_data (lut_wr_data),
        .out_valid   (out_valid),
        .out_ch      (out_ch),
        .sine_out    (sine_out),
        .cosine_out  (cosine_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable = 1'b0;
        sync_clear = 1'b0;
        cfg_wr = 1'b0;
        lut_wr_en = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic cfg(input logic [CW-1:0] ch, input logic [1:0] a,
                       input logic [PW-1:0] d);
        cfg_wr = 1'b1;
        cfg_ch = ch;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ch !== 3'd0) begin
            fails++;
            $display("FAIL reset_ctl valid=%b ch=%0d want 0/0", out_valid, out_ch);
        end
        checks++;
        if (sine_out !== 12'd0 || cosine_out !== 12'd0) begin
            fails++;
            $display("FAIL reset_data sin=%h cos=%h want 000/000", sine_out, cosine_out);
        end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 256; i++) begin
            lut_wr_en = 1'b1;
            lut_wr_addr = 8'(i);
            lut_wr_data = 11'(8 * i);
            tick();
        end
        lut_wr_en = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_valid got %b want 0", out_valid);
        end
    endtask

    task automatic test_fcw();
        logic [OW-1:0] es, ec;
        do_reset();
        cfg(3'd0, 2'd0, 24'h010000);
        enable = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL fcw_latency valid=%b after 2 cycles want 0", out_valid);
        end
        for (int s = 0; s < 256; s++) begin
            tick();
            es = (s % 4 == 0) ? 12'(32 * (s / 4)) : 12'd0;
            ec = 12'd2040 - es;
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 3'(s % 4)) begin
                fails++;
                $display("FAIL fcw_seq s=%0d valid=%b ch=%0d want 1/%0d",
                         s, out_valid, out_ch, s % 4);
            end
            checks++;
            if (sine_out !== es || cosine_out !== ec) begin
                fails++;
                $display("FAIL fcw_data s=%0d sin=%h cos=%h want %h/%h",
                         s, sine_out, cosine_out, es, ec);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_offset();
        logic [OW-1:0] es, ec;
        do_reset();
        cfg(3'd1, 2'd1, 24'h840000);
        enable = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 32; s++) begin
            tick();
            es = (s % 4 == 1) ? 12'hF80 : 12'd0;
            ec = (s % 4 == 1) ? 12'h888 : 12'd2040;
            checks++;
            if (out_ch !== 3'(s % 4) || sine_out !== es || cosine_out !== ec) begin
                fails++;
                $display("FAIL offset s=%0d ch=%0d sin=%h cos=%h want %0d/%h/%h",
                         s, out_ch, sine_out, cosine_out, s % 4, es, ec);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_quadrant();
        logic [OW-1:0] qs [4];
        logic [OW-1:0] qc [4];
        logic [OW-1:0] es, ec;
        qs = '{12'd0, 12'd2040, 12'd0, 12'h808};
        qc = '{12'd2040, 12'd0, 12'h808, 12'd0};
        do_reset();
        cfg(3'd3, 2'd0, 24'h400000);
        enable = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 32; s++) begin
            tick();
            es = (s % 4 == 3) ? qs[(s / 4) % 4] : 12'd0;
            ec = (s % 4 == 3) ? qc[(s / 4) % 4] : 12'd2040;
            checks++;
            if (out_ch !== 3'(s % 4) || sine_out !== es || cosine_out !== ec) begin
                fails++;
                $display("FAIL quadrant s=%0d ch=%0d sin=%h cos=%h want %0d/%h/%h",
                         s, out_ch, sine_out, cosine_out, s % 4, es, ec);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_sweep();
        logic [OW-1:0] es, ec;
        int s, k, p;
        do_reset();
        cfg(3'd2, 2'd2, 24'h000400);
        enable = 1'b1;
        for (int m = 0; m <= 96; m++) begin
            // FCW write lands in the same cycle as ch2 frame 16 in stage 0
            cfg_wr = (m == 66);
            cfg_ch = 3'd2;
            cfg_addr = 2'd0;
            cfg_data = '0;
            tick();
            if (m >= 2) begin
                s = m - 2;
                k = s / 4;
                p = (k <= 16) ? 512 * k * (k - 1)
                              : 'h22000 + 512 * (k - 17) * (k - 18);
                es = (s % 4 == 2) ? 12'(8 * ((p >> 14) & 255)) : 12'd0;
                ec = 12'd2040 - es;
                checks++;
                if (out_ch !== 3'(s % 4) || sine_out !== es || cosine_out !== ec) begin
                    fails++;
                    $display("FAIL sweep s=%0d ch=%0d sin=%h cos=%h want %0d/%h/%h",
                             s, out_ch, sine_out, cosine_out, s % 4, es, ec);
                end
            end
        end
        cfg_wr = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_clear_reset();
        logic [OW-1:0] es;
        do_reset();
        cfg(3'd0, 2'd0, 24'h010000);
        enable = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 40; s++) begin
            tick();
            es = (s % 4 == 0) ? 12'(32 * (s / 4)) : 12'd0;
            checks++;
            if (out_ch !== 3'(s % 4) || sine_out !== es) begin
                fails++;
                $display("FAIL pre_clear s=%0d ch=%0d sin=%h want %0d/%h",
                         s, out_ch, sine_out, s % 4, es);
            end
        end
        sync_clear = 1'b1;
        tick();
        sync_clear = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL clear_valid got %b want 0", out_valid);
        end
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL clear_drain got %b want 0", out_valid);
        end
        for (int s = 0; s < 8; s++) begin
            tick();
            es = (s % 4 == 0) ? 12'(32 * (s / 4)) : 12'd0;
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 3'(s % 4) || sine_out !== es
                || cosine_out !== 12'd2040 - es) begin
                fails++;
                $display("FAIL post_clear s=%0d v=%b ch=%0d sin=%h cos=%h want sin %h",
                         s, out_valid, out_ch, sine_out, cosine_out, es);
            end
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ch !== 3'd0 || sine_out !== 12'd0
            || cosine_out !== 12'd0) begin
            fails++;
            $display("FAIL async_reset v=%b ch=%0d sin=%h cos=%h want all 0",
                     out_valid, out_ch, sine_out, cosine_out);
        end
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_resume_early got %b want 0", out_valid);
        end
        for (int s = 0; s < 8; s++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 3'(s % 4) || sine_out !== 12'd0
                || cosine_out !== 12'd2040) begin
                fails++;
                $display("FAIL reset_resume s=%0d v=%b ch=%0d sin=%h cos=%h want 1/%0d/000/7f8",
                         s, out_valid, out_ch, sine_out, cosine_out, s % 4);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_toggle();
        logic v [3];
        int sp [3];
        int issued;
        logic en;
        logic [OW-1:0] es, last;
        v = '{1'b0, 1'b0, 1'b0};
        sp = '{0, 0, 0};
        issued = 0;
        last = '0;
        do_reset();
        cfg(3'd0, 2'd0, 24'h010000);
        for (int m = 0; m < 40; m++) begin
            en = !(m >= 10 && m < 15);
            enable = en;
            tick();
            v[2] = v[1];
            v[1] = v[0];
            v[0] = en;
            sp[2] = sp[1];
            sp[1] = sp[0];
            sp[0] = issued;
            if (en) issued++;
            if (v[2]) begin
                es = (sp[2] % 4 == 0) ? 12'(32 * (sp[2] / 4)) : 12'd0;
                last = es;
                checks++;
                if (out_valid !== 1'b1 || out_ch !== 3'(sp[2] % 4) || sine_out !== es) begin
                    fails++;
                    $display("FAIL toggle m=%0d v=%b ch=%0d sin=%h want 1/%0d/%h",
                             m, out_valid, out_ch, sine_out, sp[2] % 4, es);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0 || sine_out !== last) begin
                    fails++;
                    $display("FAIL toggle_idle m=%0d v=%b sin=%h want 0/%h",
                             m, out_valid, sine_out, last);
                end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_cfg_ignored();
        logic [OW-1:0] es;
        do_reset();
        cfg(3'd0, 2'd0, 24'h010000);
        cfg(3'd4, 2'd0, 24'h400000);
        cfg(3'd4, 2'd1, 24'h800000);
        cfg(3'd0, 2'd3, 24'h400000);
        cfg(3'd1, 2'd3, 24'h840000);
        enable = 1'b1;
        tick();
        tick();
        for (int s = 0; s < 16; s++) begin
            tick();
            es = (s % 4 == 0) ? 12'(32 * (s / 4)) : 12'd0;
            checks++;
            if (out_ch !== 3'(s % 4) || sine_out !== es
                || cosine_out !== 12'd2040 - es) begin
                fails++;
                $display("FAIL cfg_ignored s=%0d ch=%0d sin=%h cos=%h want sin %h",
                         s, out_ch, sine_out, cosine_out, es);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_lut_write();
        do_reset();
        enable = 1'b1;
        tick();
        tick();
        tick();
        lut_wr_en = 1'b1;
        lut_wr_addr = 8'd0;
        lut_wr_data = 11'h123;
        tick();
        lut_wr_en = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || sine_out !== 12'd0) begin
            fails++;
            $display("FAIL lut_before v=%b sin=%h want 1/000", out_valid, sine_out);
        end
        tick();
        checks++;
        if (sine_out !== 12'd0) begin
            fails++;
            $display("FAIL lut_same_cycle sin=%h want 000", sine_out);
        end
        tick();
        checks++;
        if (sine_out !== 12'h123 || cosine_out !== 12'd2040) begin
            fails++;
            $display("FAIL lut_after sin=%h cos=%h want 123/7f8", sine_out, cosine_out);
        end
        enable = 1'b0;
        lut_wr_en = 1'b1;
        lut_wr_data = 11'd0;
        tick();
        lut_wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fcw();
        test_offset();
        test_quadrant();
        test_sweep();
        test_clear_reset();
        test_enable_toggle();
        test_cfg_ignored();
        test_lut_write();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/multichannel_dds.md
Name: multichannel_dds

Overview:
- Time-multiplexed multi-channel direct digital synthesiser.
- NUM_CHANNELS independent phase accumulators share one host-loaded quarter-wave LUT and one 3-stage pipeline.
- Emits signed sine/cosine samples tagged with channel number; per-channel linear frequency sweep (chirp).
- Sits between the control-register bank (cfg/LUT write ports) and the downstream mixers/DACs.

Parameters:
- PHASE_WIDTH, 24, phase accumulator / FCW / offset / sweep-step width.
- OUTPUT_WIDTH, 12, signed output sample width; LUT entries are OUTPUT_WIDTH-1 bits unsigned.
- LUT_ADDR_WIDTH, 8, quarter-wave LUT address width (depth 2^LUT_ADDR_WIDTH); requires LUT_ADDR_WIDTH <= PHASE_WIDTH-2.
- NUM_CHANNELS, 4, number of channels (>=1).
- CH_WIDTH, 2, channel index width, >= clog2(NUM_CHANNELS), >= 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  advance channel scheduler.
- sync_clear  in  1  synchronous clear of all accumulators/scheduler/pipeline.
- cfg_wr  in  1  config register write strobe.
- cfg_ch  in  CH_WIDTH  target channel.
- cfg_addr  in  2  0=FCW, 1=PHASE_OFFSET, 2=SWEEP_STEP (signed), 3=reserved.
- cfg_data  in  PHASE_WIDTH  write data.
- lut_wr_en  in  1  LUT write strobe.
- lut_wr_addr  in  LUT_ADDR_WIDTH  LUT address.
- lut_wr_data  in  OUTPUT_WIDTH-1  LUT magnitude.
- out_valid  out  1  sample valid.
- out_ch  out  CH_WIDTH  channel of sample.
- sine_out  out  OUTPUT_WIDTH  signed sine.
- cosine_out  out  OUTPUT_WIDTH  signed cosine.

Behaviour:
- Reset: all accumulators, FCW, offset and step registers, ch_cnt, pipeline valids and all outputs = 0. LUT is not reset.
- Scheduler: ch_cnt cycles 0..NUM_CHANNELS-1 and wraps. Advances only when enable=1; holds when enable=0.
- Stage 0 (cycle t, enable=1, c=ch_cnt):
  - p = acc[c] + offset[c], using pre-update acc.
  - acc[c] <= acc[c] + fcw[c].
  - fcw[c] <= fcw[c] + step[c].
  - All arithmetic mod 2^PHASE_WIDTH.
- Address decode:
  - q = p[PW-1:PW-2]; i = p[PW-3:PW-2-LAW].
  - Sine index = q[0] ? ~i : i; sine negative iff q[1].
  - Cosine uses qc = q+1 (mod 4): index = qc[0] ? ~i : i; negative iff qc[1].
- Stage 1: registers indices, signs, channel. Stage 2: synchronous LUT reads (two read ports or duplicated array).
- Stage 3: output = sign ? -{0,mag} : {0,mag}, two's complement, OUTPUT_WIDTH bits.
- Latency: exactly 3 cycles. out_valid=1 with out_ch=c at cycle t+3.
- Outputs hold their last values when out_valid=0.
- enable low: no new entries; in-flight samples drain and valid deasserts.
- sync_clear=1:
  - All acc and ch_cnt <= 0; all pipeline valids and out_valid <= 0 next cycle.
  - fcw/offset/step retain their values.
  - Overrides enable in that cycle.
- Config write:
  - Takes effect from the next cycle.
  - If it targets the channel in stage 0 the same cycle, stage 0 uses old values, and a write to FCW overrides the sweep update.
  - cfg_ch >= NUM_CHANNELS or cfg_addr=3: ignored.
- LUT write: visible to reads from the next cycle. Same-cycle read of the same address returns old data.
- Async reset mid-operation: immediate clear as above; the first valid sample follows 3 cycles after enable resumes.

Test Plan:
All scenarios use defaults and lut[i]=8*i (lut[255]=2040), loaded before enable.

1. Ch0 FCW=0x010000, others 0, enable held.
   - Ch0 frame k: sine=+32k (i=4k), cosine=+(2040-32k) for k=0..63.
   - First out_valid 3 cycles after enable, out_ch sequence 0,1,2,3,0…
2. Ch1 FCW=0, OFFSET=0x840000.
   - Every ch1 sample: sine=0xF80 (-128), cosine=0x888 (-1912).
3. Ch3 FCW=0x400000 (quadrant wrap).
   - Ch3 sines repeat 0, +2040, 0, 0x808 (-2040).
   - Cosines repeat +2040, 0, 0x808, 0.
4. Ch2 FCW=0, STEP=0x000400 (sweep).
   - Frame k: phase=0x200*k*(k-1), i.e. sine = 8*floor(phase/2^14) while phase<2^22.
   - Frame 2 sine=0; frame 12 sine=32.
   - Then write FCW=0 coincident with ch2 stage 0: sweep restarts from 0.
5. Run scenario 1 for 10 frames, then:
   - pulse sync_clear: out_valid=0 next cycle; next ch0 sample sine=0, cosine=2040.
   - then assert rst_n=0 mid-frame: all outputs 0 immediately; after reset ch0 sine=0 (FCW cleared).
6. Controls and address edge cases:
   - Toggle enable low 5 cycles: ch_cnt holds, out_valid low after drain, sequence resumes without skipping.
   - cfg_ch=4 (with CH_WIDTH=3) or cfg_addr=3 writes: no output change.
   - lut_wr to addr 0 during run: old value on a same-cycle read, new value afterwards.
